// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide engine with HI/LO result registers for the
// multi-cycle MIPS datapath: shift-add multiply, restoring divide, WIDTH+1 cycles.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Two's-complement absolute value; the most-negative pattern maps onto itself,
  // which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    a_neg = ~op_i[0] & a_i[WIDTH-1];
    b_neg = ~op_i[0] & b_i[WIDTH-1];
    a_mag = a_neg ? (~a_i + WIDTH'(1)) : a_i;
    b_mag = b_neg ? (~b_i + WIDTH'(1)) : b_i;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_trial[WIDTH];
  end

  // With a zero divisor every trial succeeds, so the remainder ends up holding the
  // dividend magnitude and HI naturally comes out equal to the original a.
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          cnt_d     = CNT_INIT;
          is_div_d  = op_i[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (b_i == '0);
          rem_d     = '0;
          if (op_i[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end
        end else begin
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_LAST;
        if (is_div_q) begin
          rem_d = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = is_div_q & dz_q;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule
